// File: rtl/pet_pkg.sv
// pet_pkg: encodings shared between the pet game-logic stage and the LCD display controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package pet_pkg;

  // Mood field, select_figures[3:2]
  localparam logic [1:0] MOOD_HAPPY   = 2'b01;
  localparam logic [1:0] MOOD_SAD     = 2'b00;
  localparam logic [1:0] MOOD_NEUTRAL = 2'b10;

  // Stat field, select_figures[1:0]
  localparam logic [1:0] STAT_SALUD     = 2'b00;
  localparam logic [1:0] STAT_ALIM      = 2'b10;
  localparam logic [1:0] STAT_ENERGIA   = 2'b01;
  localparam logic [1:0] STAT_DIVERSION = 2'b11;

  // sleep output codes
  localparam logic [1:0] SLEEP_AWAKE  = 2'b00;
  localparam logic [1:0] SLEEP_ASLEEP = 2'b01;
  localparam logic [1:0] SLEEP_DEAD   = 2'b11;

  typedef enum logic [1:0] {
    ST_AWAKE    = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_DEAD     = 2'd2
  } pet_state_e;

  // Rotation order is salud -> alimentacion -> energia -> diversion; the
  // display codes are not in that numeric order, hence the lookup.
  function automatic logic [1:0] rot_code(input logic [1:0] idx);
    logic [1:0] code;
    case (idx)
      2'd0:    code = STAT_SALUD;
      2'd1:    code = STAT_ALIM;
      2'd2:    code = STAT_ENERGIA;
      default: code = STAT_DIVERSION;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer plus rising-edge detector for one raw push-button.
// Latency: o_press is high for one clk, in the third clk period after i_btn rises.
// Backpressure: none; a held button yields a single press.
// Ports: clk, reset (async, active-high), i_btn (raw, asynchronous), o_press (one-clk pulse).
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_sync2 & ~r_prev;

endmodule

// File: rtl/pet_state_engine.sv
// pet_state_engine: need levels, game tick, awake/sleeping/dead FSM and LCD selector for the virtual cat.
// Latency: button rise -> level update after 3 clk -> registered outputs after 4 clk.
// Backpressure: none; presses and decay steps are never dropped except where the FSM ignores them.
// Ports: clk; reset (async, active-high); btn_feed/play/heal/sleep (raw buttons);
//        select_figures[3:2] mood, [1:0] stat code; sleep (00 awake, 01 sleeping, 11 dead);
//        tick (one-clk pulse per game tick).
// Optional: define PET_AUTO_SLEEP_EN to send the pet to sleep when energia hits 0 while awake.
module pet_state_engine
  import pet_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int DECAY_TICKS  = 10,
  parameter int ROTATE_TICKS = 3,
  parameter int STAT_W       = 3,
  parameter int STAT_MAX     = 7,
  parameter int INIT_LEVEL   = 5,
  parameter int HAPPY_TH     = 5,
  parameter int SAD_TH       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_feed,
  input  logic       btn_play,
  input  logic       btn_heal,
  input  logic       btn_sleep,
  output logic [3:0] select_figures,
  output logic [1:0] sleep,
  output logic       tick
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DEC_W  = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int ROT_W  = (ROTATE_TICKS > 1) ? $clog2(ROTATE_TICKS) : 1;
  // Two extra bits so decay-then-button sums can go below 0 or above STAT_MAX before saturating.
  localparam int LW     = STAT_W + 2;

  localparam logic signed [LW-1:0] L_ONE = LW'(1);
  localparam logic signed [LW-1:0] L_TWO = LW'(2);
  localparam logic signed [LW-1:0] L_MAX = LW'(STAT_MAX);
  localparam logic [STAT_W-1:0] S_MAX   = STAT_W'(STAT_MAX);
  localparam logic [STAT_W-1:0] S_INIT  = STAT_W'(INIT_LEVEL);
  localparam logic [STAT_W-1:0] S_HAPPY = STAT_W'(HAPPY_TH);
  localparam logic [STAT_W-1:0] S_SAD   = STAT_W'(SAD_TH);

  function automatic logic [STAT_W-1:0] sat(input logic signed [LW-1:0] v);
    logic [STAT_W-1:0] r;
    if (v[LW-1])        r = '0;
    else if (v > L_MAX) r = S_MAX;
    else                r = v[STAT_W-1:0];
    return r;
  endfunction

  logic w_feed, w_play, w_heal, w_sleep;

  btn_sync_edge u_feed  (.clk(clk), .reset(reset), .i_btn(btn_feed),  .o_press(w_feed));
  btn_sync_edge u_play  (.clk(clk), .reset(reset), .i_btn(btn_play),  .o_press(w_play));
  btn_sync_edge u_heal  (.clk(clk), .reset(reset), .i_btn(btn_heal),  .o_press(w_heal));
  btn_sync_edge u_sleep (.clk(clk), .reset(reset), .i_btn(btn_sleep), .o_press(w_sleep));

  logic [TICK_W-1:0] r_tick_cnt;
  logic [DEC_W-1:0]  r_decay_cnt;
  logic [ROT_W-1:0]  r_rot_cnt;
  logic [1:0]        r_rot_idx;
  logic [STAT_W-1:0] r_salud, r_alim, r_energia, r_div;
  pet_state_e        r_state;
  logic [3:0]        r_select;
  logic [1:0]        r_sleep;
  logic              r_tick;

  logic w_wrap, w_decay, w_rot_step;
  assign w_wrap     = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
  assign w_decay    = w_wrap && (r_decay_cnt == DEC_W'(DECAY_TICKS - 1));
  assign w_rot_step = w_wrap && (r_rot_cnt == ROT_W'(ROTATE_TICKS - 1));

  // Next levels: decay first, then buttons, saturation last.
  logic signed [LW-1:0] w_sal, w_ali, w_ene, w_div;
  always_comb begin
    w_sal = $signed({2'b00, r_salud});
    w_ali = $signed({2'b00, r_alim});
    w_ene = $signed({2'b00, r_energia});
    w_div = $signed({2'b00, r_div});
    if (w_decay) begin
      if (r_alim == '0 || r_energia == '0) w_sal = w_sal - L_ONE;
      w_ali = w_ali - L_ONE;
      if (r_state == ST_SLEEPING) begin
        w_ene = w_ene + L_ONE;
      end else begin
        w_ene = w_ene - L_ONE;
        w_div = w_div - L_ONE;
      end
    end
    if (r_state == ST_AWAKE) begin
      if (w_feed) w_ali = w_ali + L_TWO;
      if (w_play) begin
        w_div = w_div + L_TWO;
        w_ene = w_ene - L_ONE;
      end
      if (w_heal) w_sal = w_sal + L_ONE;
    end
  end

  // Lowest level with salud > alimentacion > energia > diversion tie priority (strict < keeps the earlier one).
  logic [STAT_W-1:0] w_min;
  logic [1:0]        w_low, w_mood, w_stat;
  always_comb begin
    w_min = r_salud;
    w_low = STAT_SALUD;
    if (r_alim < w_min)    begin w_min = r_alim;    w_low = STAT_ALIM;      end
    if (r_energia < w_min) begin w_min = r_energia; w_low = STAT_ENERGIA;   end
    if (r_div < w_min)     begin w_min = r_div;     w_low = STAT_DIVERSION; end
    if (w_min >= S_HAPPY)   w_mood = MOOD_HAPPY;
    else if (w_min <= S_SAD) w_mood = MOOD_SAD;
    else                     w_mood = MOOD_NEUTRAL;
    w_stat = (w_mood == MOOD_SAD) ? w_low : rot_code(r_rot_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt  <= '0;
      r_decay_cnt <= '0;
      r_rot_cnt   <= '0;
      r_rot_idx   <= 2'd0;
      r_salud     <= S_INIT;
      r_alim      <= S_INIT;
      r_energia   <= S_INIT;
      r_div       <= S_INIT;
      r_state     <= ST_AWAKE;
      r_select    <= {MOOD_HAPPY, STAT_SALUD};
      r_sleep     <= SLEEP_AWAKE;
      r_tick      <= 1'b0;
    end else begin
      r_tick_cnt <= w_wrap ? '0 : r_tick_cnt + 1'b1;
      r_tick     <= w_wrap;
      if (w_wrap) begin
        r_decay_cnt <= w_decay ? '0 : r_decay_cnt + 1'b1;
        r_rot_cnt   <= w_rot_step ? '0 : r_rot_cnt + 1'b1;
      end
      if (w_rot_step) r_rot_idx <= r_rot_idx + 2'd1;

      // A zero salud freezes everything from this cycle on, so a late heal cannot revive the pet.
      if (r_state != ST_DEAD && r_salud == '0) begin
        r_state <= ST_DEAD;
      end else if (r_state != ST_DEAD) begin
        r_salud   <= sat(w_sal);
        r_alim    <= sat(w_ali);
        r_energia <= sat(w_ene);
        r_div     <= sat(w_div);
        case (r_state)
          ST_AWAKE: begin
            if (w_sleep) r_state <= ST_SLEEPING;
`ifdef PET_AUTO_SLEEP_EN
            else if (r_energia == '0) r_state <= ST_SLEEPING;
`endif
          end
          ST_SLEEPING: begin
            if (w_sleep || r_energia == S_MAX) r_state <= ST_AWAKE;
          end
          default: r_state <= r_state;
        endcase
      end

      case (r_state)
        ST_SLEEPING: r_sleep <= SLEEP_ASLEEP;
        ST_DEAD:     r_sleep <= SLEEP_DEAD;
        default:     r_sleep <= SLEEP_AWAKE;
      endcase
      r_select <= (r_state == ST_DEAD) ? 4'b0000 : {w_mood, w_stat};
    end
  end

  assign select_figures = r_select;
  assign sleep          = r_sleep;
  assign tick           = r_tick;

endmodule

// File: tb/tb_pet_state_engine.sv
// tb_pet_state_engine: directed stimulus with a behavioural pet model checked every clk.
// Latency: n/a.
// Backpressure: n/a.
module tb_pet_state_engine;

  localparam int TD = 4, DT = 2, RT = 1;
  localparam int SMAX = 7, INIT = 5, HTH = 5, STH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_feed = 1'b0, btn_play = 1'b0, btn_heal = 1'b0, btn_sleep = 1'b0;
  logic [3:0] select_figures;
  logic [1:0] sleep;
  logic       tick;

  int n_cmp = 0;
  int n_bad = 0;

  pet_state_engine #(
    .TICK_DIV(TD), .DECAY_TICKS(DT), .ROTATE_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_feed(btn_feed), .btn_play(btn_play), .btn_heal(btn_heal), .btn_sleep(btn_sleep),
    .select_figures(select_figures), .sleep(sleep), .tick(tick)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // lv index: 0 salud, 1 alimentacion, 2 energia, 3 diversion (also tie priority and rotation order)
  int lv[4];
  int mstate;        // 0 awake, 1 sleeping, 2 dead
  int tcnt, dcnt, rcnt, rot;
  logic [2:0] hf, hp, hh, hs;   // raw input samples at the last three edges, newest in bit 0
  logic [3:0] exp_sel;
  logic [1:0] exp_sleep;
  logic       exp_tick;
  bit         mdl_on = 1'b0;
  bit         saw_asleep = 1'b0;

  function automatic logic [1:0] code_of(input int i);
    logic [1:0] c [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    return c[i];
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > SMAX) ? SMAX : v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) lv[i] = INIT;
    mstate = 0; tcnt = 0; dcnt = 0; rcnt = 0; rot = 0;
    hf = '0; hp = '0; hh = '0; hs = '0;
    exp_sel = 4'b0100; exp_sleep = 2'b00; exp_tick = 1'b0;
  endtask

  task automatic model_outputs();
    int mn, lo;
    logic [1:0] mood;
    if (mstate == 2) begin
      exp_sel = 4'b0000; exp_sleep = 2'b11;
    end else begin
      mn = lv[0]; lo = 0;
      for (int i = 1; i < 4; i++) if (lv[i] < mn) begin mn = lv[i]; lo = i; end
      mood = (mn >= HTH) ? 2'b01 : ((mn <= STH) ? 2'b00 : 2'b10);
      exp_sel = {mood, (mood == 2'b00) ? code_of(lo) : code_of(rot)};
      exp_sleep = (mstate == 1) ? 2'b01 : 2'b00;
    end
  endtask

  task automatic model_step();
    int nl[4];
    bit wrap, dec, pf, pp, ph, ps;
    model_outputs();
    wrap = (tcnt == TD - 1);
    exp_tick = wrap;
    pf = hf[1] & ~hf[2]; pp = hp[1] & ~hp[2]; ph = hh[1] & ~hh[2]; ps = hs[1] & ~hs[2];
    hf = {hf[1:0], btn_feed}; hp = {hp[1:0], btn_play};
    hh = {hh[1:0], btn_heal}; hs = {hs[1:0], btn_sleep};
    dec = wrap && (dcnt == DT - 1);
    if (wrap && rcnt == RT - 1) rot = (rot + 1) % 4;
    tcnt = wrap ? 0 : tcnt + 1;
    if (wrap) begin dcnt = (dcnt + 1) % DT; rcnt = (rcnt + 1) % RT; end
    if (mstate == 2) return;
    if (lv[0] == 0) begin mstate = 2; return; end
    for (int i = 0; i < 4; i++) nl[i] = lv[i];
    if (dec) begin
      if (lv[1] == 0 || lv[2] == 0) nl[0] -= 1;
      nl[1] -= 1;
      if (mstate == 1) nl[2] += 1;
      else begin nl[2] -= 1; nl[3] -= 1; end
    end
    if (mstate == 0) begin
      if (pf) nl[1] += 2;
      if (pp) begin nl[3] += 2; nl[2] -= 1; end
      if (ph) nl[0] += 1;
      if (ps) mstate = 1;
`ifdef PET_AUTO_SLEEP_EN
      else if (lv[2] == 0) mstate = 1;
`endif
    end else if (ps || lv[2] == SMAX) begin
      mstate = 0;
    end
    for (int i = 0; i < 4; i++) lv[i] = clamp(nl[i]);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mdl_on) begin
      chk("model_select", select_figures, exp_sel);
      chk("model_sleep", {2'b00, sleep}, {2'b00, exp_sleep});
      chk("model_tick", {3'b000, tick}, {3'b000, exp_tick});
    end
    if (sleep == 2'b01) saw_asleep = 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sleep(input logic [1:0] v, input int lim);
    for (int i = 0; i < lim && sleep !== v; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    btn_feed = 0; btn_play = 0; btn_heal = 0; btn_sleep = 0;
    cycles(2);
    reset = 1'b0;
  endtask

  initial begin
    cycles(2);
    chk("reset_select", select_figures, 4'b0100);
    chk("reset_sleep", {2'b00, sleep}, 4'b0000);
    chk("reset_tick", {3'b000, tick}, 4'b0000);
    mdl_on = 1'b1;
    reset = 1'b0;

    // Tick and rotation from reset release (edge numbering from release)
    cycles(4);
    chk("tick_at_4", {3'b000, tick}, 4'b0001);
    cycles(1);
    chk("rot_alim_5", select_figures, 4'b0110);
    cycles(4);
    chk("decay1_neutral_9", select_figures, 4'b1001);
    cycles(8);
    chk("rot_back_salud_17", select_figures, 4'b1000);

    // Held feed: one press only
    btn_feed = 1'b1;
    cycles(20);
    btn_feed = 1'b0;

    // Starve until death, then buttons must not matter
    wait_sleep(2'b11, 300);
    chk("dead_sleep", {2'b00, sleep}, 4'b0011);
    chk("dead_select", select_figures, 4'b0000);
    btn_heal = 1'b1; btn_feed = 1'b1; btn_sleep = 1'b1;
    cycles(10);
    btn_heal = 1'b0; btn_feed = 1'b0; btn_sleep = 1'b0;
    cycles(20);
    chk("dead_frozen", {2'b00, sleep}, 4'b0011);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("dead_reset_select", select_figures, 4'b0100);
    chk("dead_reset_sleep", {2'b00, sleep}, 4'b0000);
    cycles(2);
    reset = 1'b0;

    // Sleep, ignored play, wake on full energia
    btn_sleep = 1'b1; cycles(2); btn_sleep = 1'b0;
    wait_sleep(2'b01, 10);
    chk("enter_sleep", {2'b00, sleep}, 4'b0001);
    btn_play = 1'b1; cycles(2); btn_play = 1'b0;
    wait_sleep(2'b00, 100);
    chk("wake_full_energia", {2'b00, sleep}, 4'b0000);

    // Reset in the middle of sleeping
    btn_sleep = 1'b1; cycles(2); btn_sleep = 1'b0;
    wait_sleep(2'b01, 10);
    chk("sleep_again", {2'b00, sleep}, 4'b0001);
    cycles(3);
    reset = 1'b1;
    #1;
    chk("mid_sleep_reset_sleep", {2'b00, sleep}, 4'b0000);
    chk("mid_sleep_reset_select", select_figures, 4'b0100);
    cycles(2);
    reset = 1'b0;

    // Exhaust energia with repeated play presses
    saw_asleep = 1'b0;
    for (int k = 0; k < 6; k++) begin
      btn_play = 1'b1; cycles(2);
      btn_play = 1'b0; cycles(2);
    end
    cycles(40);
`ifdef PET_AUTO_SLEEP_EN
    chk("auto_sleep_seen", {3'b000, saw_asleep}, 4'b0001);
`else
    chk("no_auto_sleep", {3'b000, saw_asleep}, 4'b0000);
`endif

    do_reset();
    cycles(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
